// File: rtl/sram_lsu_pkg.sv
// Shared definitions for the LSU data-side SRAM model: the default memory window,
// the store size codes, and the helpers that place store data onto byte lanes.
package sram_lsu_pkg;

  localparam logic [31:0] MEM_BASE_ADDR = 32'h8000_0000;

  localparam logic [7:0] WMASK_B = 8'h01;
  localparam logic [7:0] WMASK_H = 8'h03;
  localparam logic [7:0] WMASK_W = 8'h0F;

  // Lanes pushed past byte 3 fall off the top, so a misaligned store never spills.
  function automatic logic [3:0] lane_be(input logic [3:0] size, input logic [1:0] off);
    return 4'({3'b000, size} << off);
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

endpackage

// File: rtl/sram_lsu.sv
// Byte-addressable data SRAM for the LSU: registered full-word reads (latency 1),
// byte-masked sb/sh/sw stores, read-first on same-word collisions.
module sram_lsu
  import sram_lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MEM_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] raddr,
  input  logic [31:0] waddr,
  input  logic [7:0]  wmask,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] TOP_ADR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]   w_roff;
  logic [31:0]   w_woff;
  logic          w_rin;
  logic          w_win;
  logic [AW-1:0] w_ridx;
  logic [AW-1:0] w_widx;
  logic [3:0]    w_sbe;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic          w_unused;

  assign w_roff = raddr - BASE_ADDR;
  assign w_woff = waddr - BASE_ADDR;
  // Compare in 33 bits so a window ending at 2^32 cannot wrap.
  assign w_rin  = (raddr >= BASE_ADDR) && ({1'b0, raddr} < TOP_ADR);
  assign w_win  = (waddr >= BASE_ADDR) && ({1'b0, waddr} < TOP_ADR);
  assign w_ridx = w_roff[AW+1:2];
  assign w_widx = w_woff[AW+1:2];

  assign w_sbe = lane_be(wmask[3:0], waddr[1:0]);
  assign w_wd  = lane_data(wdata, waddr[1:0]);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign w_be[g] = w_en & w_win & w_sbe[g];
  end

  assign w_unused = ^{wmask[7:4], w_roff[31:AW+2], w_roff[1:0],
                      w_woff[31:AW+2], w_woff[1:0]};

  // The array has no reset: stores keep following the clock while rst_n is low.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (r_en) begin
      rdata <= w_rin ? r_mem[w_ridx] : '0;
    end
  end

endmodule

// File: tb/tb_sram_lsu.sv
// Directed bench for sram_lsu: reset, sw/sh/sb stores, misaligned lanes,
// read/write collisions, window boundaries and reset during a store.
module tb_sram_lsu;
  import sram_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] raddr = '0;
  logic [31:0] waddr = '0;
  logic [7:0]  wmask = '0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;

  sram_lsu #(
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH_WORDS(65536)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .raddr(raddr),
    .waddr(waddr),
    .wmask(wmask),
    .w_en (w_en),
    .r_en (r_en),
    .wdata(wdata),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  // Stimulus tasks are entered and left on a falling edge.
  task automatic wr(input logic [31:0] a, input logic [7:0] m, input logic [31:0] d);
    w_en = 1'b1; waddr = a; wmask = m; wdata = d;
    @(negedge clk);
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    r_en = 1'b1; raddr = a;
    @(negedge clk);
    r_en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_async got=%h exp=%h", rdata, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_hold got=%h exp=%h", rdata, 32'h0); end
    rd(32'h0000_1000);
    checks++;
    if (rdata !== 32'h0 || $isunknown(rdata)) begin failures++; $display("FAIL reset_read_noX got=%h exp=%h", rdata, 32'h0); end
  endtask

  task automatic test_word_store();
    wr(32'h8000_0010, WMASK_W, 32'hDEAD_BEEF);
    r_en = 1'b1; raddr = 32'h8000_0012;
    #1;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL word_latency got=%h exp=%h", rdata, 32'h0); end
    @(negedge clk);
    r_en = 1'b0;
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL word_store got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
  endtask

  task automatic test_byte_half();
    wr(32'h8000_0010, WMASK_W, 32'h1122_3344);
    wr(32'h8000_0011, WMASK_B, 32'h0000_00AA);
    rd(32'h8000_0010);
    checks++;
    if (rdata !== 32'h1122_AA44) begin failures++; $display("FAIL byte_store got=%h exp=%h", rdata, 32'h1122_AA44); end
    wr(32'h8000_0012, WMASK_H, 32'h0000_BEEF);
    rd(32'h8000_0010);
    checks++;
    if (rdata !== 32'hBEEF_AA44) begin failures++; $display("FAIL half_store got=%h exp=%h", rdata, 32'hBEEF_AA44); end
    wr(32'h8000_0010, 8'h00, 32'hFFFF_FFFF);
    wr(32'h8000_0013, 8'hF1, 32'h1234_5655);
    rd(32'h8000_0010);
    checks++;
    if (rdata !== 32'h55EF_AA44) begin failures++; $display("FAIL mask_zero_hi_ignored got=%h exp=%h", rdata, 32'h55EF_AA44); end
  endtask

  task automatic test_misaligned();
    wr(32'h8000_0000, WMASK_W, 32'h0000_0000);
    wr(32'h8000_0004, WMASK_W, 32'hCAFE_F00D);
    wr(32'h8000_0013 - 32'h10, WMASK_H, 32'h0000_CCDD);
    rd(32'h8000_0000);
    checks++;
    if (rdata !== 32'hDD00_0000) begin failures++; $display("FAIL misaligned_half got=%h exp=%h", rdata, 32'hDD00_0000); end
    rd(32'h8000_0004);
    checks++;
    if (rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL misaligned_nospill got=%h exp=%h", rdata, 32'hCAFE_F00D); end
  endtask

  task automatic test_collision();
    wr(32'h8000_0020, WMASK_W, 32'h0000_0001);
    w_en = 1'b1; waddr = 32'h8000_0020; wmask = WMASK_W; wdata = 32'h0000_0002;
    r_en = 1'b1; raddr = 32'h8000_0020;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    checks++;
    if (rdata !== 32'h0000_0001) begin failures++; $display("FAIL same_word_read_first got=%h exp=%h", rdata, 32'h1); end
    rd(32'h8000_0020);
    checks++;
    if (rdata !== 32'h0000_0002) begin failures++; $display("FAIL same_word_next got=%h exp=%h", rdata, 32'h2); end
    raddr = 32'h8000_0010;
    repeat (3) @(negedge clk);
    checks++;
    if (rdata !== 32'h0000_0002) begin failures++; $display("FAIL read_hold got=%h exp=%h", rdata, 32'h2); end
    w_en = 1'b1; waddr = 32'h8000_0024; wmask = WMASK_W; wdata = 32'h0000_0003;
    r_en = 1'b1; raddr = 32'h8000_0010;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    checks++;
    if (rdata !== 32'h55EF_AA44) begin failures++; $display("FAIL diff_word_read got=%h exp=%h", rdata, 32'h55EF_AA44); end
    rd(32'h8000_0024);
    checks++;
    if (rdata !== 32'h0000_0003) begin failures++; $display("FAIL diff_word_write got=%h exp=%h", rdata, 32'h3); end
  endtask

  task automatic test_range();
    wr(32'h8003_FFFC, WMASK_W, 32'hA5A5_A5A5);
    wr(32'h7FFF_FFFC, WMASK_W, 32'h9999_9999);
    wr(32'h8004_0000, WMASK_W, 32'h7777_7777);
    rd(32'h8003_FFFC);
    checks++;
    if (rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL last_word got=%h exp=%h", rdata, 32'hA5A5_A5A5); end
    rd(32'h8004_0000);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL read_above_top got=%h exp=%h", rdata, 32'h0); end
    rd(32'h8003_FFFF);
    checks++;
    if (rdata !== 32'hA5A5_A5A5) begin failures++; $display("FAIL last_byte_addr got=%h exp=%h", rdata, 32'hA5A5_A5A5); end
    rd(32'h7FFF_FFFC);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL read_below_base got=%h exp=%h", rdata, 32'h0); end
    rd(32'h8000_0000);
    checks++;
    if (rdata !== 32'hDD00_0000) begin failures++; $display("FAIL oor_write_no_alias got=%h exp=%h", rdata, 32'hDD00_0000); end
  endtask

  task automatic test_reset_mid();
    rd(32'h8000_0024);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_mid_async got=%h exp=%h", rdata, 32'h0); end
    @(negedge clk);
    w_en = 1'b1; waddr = 32'h8000_0028; wmask = WMASK_W; wdata = 32'h0000_0077;
    r_en = 1'b1; raddr = 32'h8000_0024;
    @(negedge clk);
    w_en = 1'b0; r_en = 1'b0;
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL reset_read_blocked got=%h exp=%h", rdata, 32'h0); end
    rst_n = 1'b1;
    @(negedge clk);
    rd(32'h8000_0028);
    checks++;
    if (rdata !== 32'h0000_0077) begin failures++; $display("FAIL write_during_reset got=%h exp=%h", rdata, 32'h77); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_half();
    test_misaligned();
    test_collision();
    test_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
